// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of every signal between the data-memory arbiter, its two requesters
// (core = 0, loader/debug = 1) and the single-port data memory.
//
//   req0/1, wen0/1, lock0/1, addr0/1, wdata0/1  : requester -> arbiter
//   gnt0/1, rvalid0/1, rdata0/1                 : arbiter -> requester
//   mem_en, mem_wen, mem_addr, mem_wdata        : arbiter -> memory
//   mem_rdata                                   : memory -> arbiter
//
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory)
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              wen0;
    logic              wen1;
    logic              lock0;
    logic              lock1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, wen0, wen1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, wen0, wen1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the core (requester 0) and the
// loader/debug agent (requester 1). Round-robin arbitration, optional bounded
// lock for bursts, and routing of the 1-cycle-late read data back to the
// requester that issued the read. Grant is combinational in the request
// cycle, so a granted access reaches the memory pins in that same cycle.
//
// Ports:
//   i_clock : system clock, all state on rising edge
//   i_reset : synchronous active-high reset; outputs forced idle while high
//   bus     : dmem_arbiter_if.slave (requester and memory signals)
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic           i_clock,
    input  logic           i_reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } lock_state_t;

    lock_state_t      r_state;
    logic             r_lock_owner;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_last_grant;
    logic             r_rd_pend;
    logic             r_rd_owner;

    logic [1:0]       w_req;
    logic [1:0]       w_lock;
    logic [1:0]       w_wen;
    logic             w_hold;
    logic             w_grant;
    logic             w_sel;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_keep_lock;

    assign w_req  = {bus.req1,  bus.req0};
    assign w_lock = {bus.lock1, bus.lock0};
    assign w_wen  = {bus.wen1,  bus.wen0};

    // The lock only holds while the owner is still asking for it this cycle;
    // dropping either req or lock hands arbitration back to round-robin at once.
    assign w_hold = (r_state == ST_LOCKED) && w_req[r_lock_owner] && w_lock[r_lock_owner];

    always_comb begin
        w_grant = 1'b0;
        w_sel   = 1'b0;
        if (i_reset) begin
            w_grant = 1'b0;
        end else if (w_hold) begin
            w_grant = 1'b1;
            w_sel   = r_lock_owner;
        end else if (&w_req) begin
            w_grant = 1'b1;
            w_sel   = ~r_last_grant;
        end else if (w_req[0]) begin
            w_grant = 1'b1;
            w_sel   = 1'b0;
        end else if (w_req[1]) begin
            w_grant = 1'b1;
            w_sel   = 1'b1;
        end
    end

    // Count of locked grants including this one. The stored count never
    // exceeds LOCK_MAX-1: the grant that would bring it to LOCK_MAX is the last
    // one of the burst, which caps a burst at exactly LOCK_MAX grants.
    assign w_cnt_inc   = w_hold ? (r_lock_cnt + CNT_W'(1)) : CNT_W'(1);
    assign w_keep_lock = w_grant && w_lock[w_sel] && (w_cnt_inc < CNT_W'(LOCK_MAX));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_UNLOCKED;
            r_lock_owner <= 1'b0;
            r_lock_cnt   <= '0;
            r_last_grant <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_sel;
                r_rd_owner   <= w_sel;
            end
            r_rd_pend <= w_grant && !w_wen[w_sel];

            case (r_state)
                ST_UNLOCKED,
                ST_LOCKED: begin
                    if (w_keep_lock) begin
                        r_state      <= ST_LOCKED;
                        r_lock_owner <= w_sel;
                        r_lock_cnt   <= w_cnt_inc;
                    end else begin
                        r_state      <= ST_UNLOCKED;
                        r_lock_cnt   <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_UNLOCKED;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.gnt0      = w_grant && !w_sel;
    assign bus.gnt1      = w_grant &&  w_sel;
    assign bus.mem_en    = w_grant;
    assign bus.mem_wen   = w_grant && w_wen[w_sel];
    assign bus.mem_addr  = !w_grant ? '0 : (w_sel ? bus.addr1  : bus.addr0);
    assign bus.mem_wdata = !w_grant ? '0 : (w_sel ? bus.wdata1 : bus.wdata0);

    // Read return: memory data arrives the cycle after the granted read.
    assign bus.rvalid0 = r_rd_pend && !r_rd_owner && !i_reset;
    assign bus.rvalid1 = r_rd_pend &&  r_rd_owner && !i_reset;
    assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
    assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;
endmodule
